// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction game round controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GO    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FALSE = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,15,13,4 expressed as bit positions 15,14,12,3.
    localparam logic [15:0] LFSR_TAPS = 16'hD008;
    localparam int unsigned RT_W      = 14;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, one step per clock; a non-zero seed keeps it out of the lock-up state.
module lfsr16
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/reaction_sequencer.sv
// Round controller for the reaction game: random dark delay, lit phase timing, false-start detect.
// Define REACT_BEST_EN to add the best_ms port and best-time register.
module reaction_sequencer
    import reaction_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned MIN_DLY  = 1000,
    parameter int unsigned DLY_BITS = 11,
    parameter int unsigned RT_MAX   = 9999
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            react,
    output logic            disp,
    output logic [RT_W-1:0] rt_ms,
    output logic            rt_valid,
    output logic            false_start,
    output logic            busy
`ifdef REACT_BEST_EN
    ,
    output logic [RT_W-1:0] best_ms
`endif
);

    localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DLY_MIN_W = $clog2(MIN_DLY + 1);
    localparam int unsigned DLY_W     = ((DLY_BITS > DLY_MIN_W) ? DLY_BITS : DLY_MIN_W) + 1;

    state_e               state_q;
    logic                 start_q, react_q;
    logic [PRESC_W-1:0]   presc_q;
    logic [DLY_W-1:0]     dly_q;
    logic [RT_W-1:0]      rt_cnt_q;
    logic [RT_W-1:0]      rt_ms_q;
    logic                 rt_valid_q, false_start_q, disp_q;
    logic [15:0]          lfsr_q;

    logic                 s_rise, r_rise, tick, rt_at_max;
    logic [DLY_W-1:0]     dly_d;
    logic [RT_W-1:0]      rt_cnt_d;
    logic                 unused_lfsr;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign s_rise      = start & ~start_q;
    assign r_rise      = react & ~react_q;
    assign tick        = (presc_q == PRESC_W'(DIV - 1));
    assign rt_at_max   = (rt_cnt_q == RT_W'(RT_MAX));
    assign dly_d       = DLY_W'(MIN_DLY) + DLY_W'(lfsr_q[DLY_BITS-1:0]);
    assign rt_cnt_d    = rt_at_max ? rt_cnt_q : rt_cnt_q + RT_W'(1);
    assign unused_lfsr = ^lfsr_q[15:DLY_BITS];

    assign disp        = disp_q;
    assign rt_ms       = rt_ms_q;
    assign rt_valid    = rt_valid_q;
    assign false_start = false_start_q;
    assign busy        = (state_q == ST_WAIT) || (state_q == ST_GO);

`ifdef REACT_BEST_EN
    logic [RT_W-1:0] best_q;
    assign best_ms = best_q;
`endif

    // Round FSM; every state change also restarts the tick prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            react_q       <= 1'b0;
            presc_q       <= '0;
            dly_q         <= '0;
            rt_cnt_q      <= '0;
            rt_ms_q       <= '0;
            rt_valid_q    <= 1'b0;
            false_start_q <= 1'b0;
            disp_q        <= 1'b1;
`ifdef REACT_BEST_EN
            best_q        <= RT_W'(RT_MAX);
`endif
        end else begin
            start_q <= start;
            react_q <= react;
            presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
            case (state_q)
                ST_IDLE, ST_DONE, ST_FALSE: begin
                    disp_q <= 1'b1;
                    if (s_rise) begin
                        state_q       <= ST_WAIT;
                        presc_q       <= '0;
                        dly_q         <= dly_d;
                        rt_valid_q    <= 1'b0;
                        false_start_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_rise) begin
                        state_q       <= ST_FALSE;
                        presc_q       <= '0;
                        false_start_q <= 1'b1;
                    end else if (tick) begin
                        if (dly_q == DLY_W'(1)) begin
                            state_q  <= ST_GO;
                            presc_q  <= '0;
                            rt_cnt_q <= '0;
                            disp_q   <= 1'b0;
                        end else begin
                            dly_q <= dly_q - DLY_W'(1);
                        end
                    end
                end
                ST_GO: begin
                    if (r_rise || rt_at_max) begin
                        state_q    <= ST_DONE;
                        presc_q    <= '0;
                        rt_ms_q    <= rt_cnt_q;
                        rt_valid_q <= 1'b1;
                        disp_q     <= 1'b1;
`ifdef REACT_BEST_EN
                        // A timeout is not a reaction and never sets a record.
                        if (!rt_at_max && (rt_cnt_q < best_q)) begin
                            best_q <= rt_cnt_q;
                        end
`endif
                    end else if (tick) begin
                        rt_cnt_q <= rt_cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    disp_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_sequencer.sv
// Scoreboard bench for reaction_sequencer: 10 clk per tick, MIN_DLY=5, DLY_BITS=2, short timeout.
module tb_reaction_sequencer;

    localparam int P      = 10;   // clocks per tick
    localparam int RT_MAX = 60;   // kept small so the timeout round stays short

    typedef struct {
        string nm;
        int    rt;
        int    valid;
        int    fs;
        int    best;
    } exp_t;

    logic        clk, rst, start, react;
    logic        disp, rt_valid, false_start, busy;
    logic [13:0] rt_ms;
`ifdef REACT_BEST_EN
    logic [13:0] best_ms;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t expq[$];
    exp_t e;
    logic [15:0] m_lfsr;
    int   exp_dly;
    int   exp_best = RT_MAX;
    int   exp_last = 0;
    logic prev_valid = 1'b0;
    logic prev_fs    = 1'b0;

    reaction_sequencer #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .MIN_DLY  (5),
        .DLY_BITS (2),
        .RT_MAX   (RT_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .react       (react),
        .disp        (disp),
        .rt_ms       (rt_ms),
        .rt_valid    (rt_valid),
        .false_start (false_start),
        .busy        (busy)
`ifdef REACT_BEST_EN
        ,
        .best_ms     (best_ms)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^15+x^13+x^4, shifted left, feedback into bit 0.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: a result is presented when rt_valid or false_start rises.
    always @(negedge clk) begin
        if (!rst && ((rt_valid && !prev_valid) || (false_start && !prev_fs))) begin
            if (expq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = expq.pop_front();
                chk({e.nm, "_rt_ms"}, int'(rt_ms), e.rt);
                chk({e.nm, "_rt_valid"}, int'(rt_valid), e.valid);
                chk({e.nm, "_false_start"}, int'(false_start), e.fs);
                chk({e.nm, "_disp"}, int'(disp), 1);
                chk({e.nm, "_busy"}, int'(busy), 0);
`ifdef REACT_BEST_EN
                chk({e.nm, "_best_ms"}, int'(best_ms), e.best);
`endif
            end
        end
        prev_valid = rt_valid;
        prev_fs    = false_start;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string nm, input int rt, input int valid, input int fs);
        exp_t x;
        x.nm = nm; x.rt = rt; x.valid = valid; x.fs = fs; x.best = exp_best;
        expq.push_back(x);
    endtask

    task automatic press_start();
        exp_dly = 5 + int'(m_lfsr[1:0]);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Measures the dark delay from the start edge to the first lit cycle.
    task automatic wait_go(input string nm);
        int n = 0;
        while (disp && n < 200) begin
            step(1);
            n++;
        end
        chk({nm, "_delay_cycles"}, n, exp_dly * P);
        chk({nm, "_busy_in_go"}, int'(busy), 1);
    endtask

    // Called right after wait_go plus 'already' extra cycles; presses react at 'ticks'.
    task automatic react_after(input string nm, input int ticks, input int already);
        step(ticks * P - already);
        react = 1'b1;
        exp_last = ticks;
        if (ticks < exp_best) exp_best = ticks;
        push(nm, ticks, 1, 0);
        step(1);
        react = 1'b0;
        chk({nm, "_latency"}, int'(rt_valid), 1);
        step(2);
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, "_disp"}, int'(disp), 1);
        chk({nm, "_rt_ms"}, int'(rt_ms), 0);
        chk({nm, "_rt_valid"}, int'(rt_valid), 0);
        chk({nm, "_false_start"}, int'(false_start), 0);
        chk({nm, "_busy"}, int'(busy), 0);
`ifdef REACT_BEST_EN
        chk({nm, "_best_ms"}, int'(best_ms), RT_MAX);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic low_seen;
        rst = 1'b1; start = 1'b0; react = 1'b0;
        step(3);
        rst = 1'b0;
        reset_checks("reset");

        // Normal round: react at 37 ticks.
        press_start();
        chk("r1_busy_after_start", int'(busy), 1);
        chk("r1_disp_after_start", int'(disp), 1);
        wait_go("r1");
        react_after("r1", 37, 0);

        // False start two ticks into the dark phase.
        press_start();
        step(2 * P);
        react = 1'b1;
        push("fs", exp_last, 0, 1);
        step(1);
        react = 1'b0;
        chk("fs_latency", int'(false_start), 1);
        low_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!disp) low_seen = 1'b1;
            step(1);
        end
        chk("fs_disp_never_lit", int'(low_seen), 0);
        chk("fs_not_busy", int'(busy), 0);

        // Next start clears the false start; reset lands at tick 20 of GO.
        press_start();
        chk("rst_round_fs_cleared", int'(false_start), 0);
        chk("rst_round_busy", int'(busy), 1);
        wait_go("rst_round");
        step(20 * P);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_best = RT_MAX;
        exp_last = 0;
        reset_checks("midround_rst");

        // Start and react in the same IDLE cycle: start wins.
        react = 1'b1;
        press_start();
        chk("same_cycle_busy", int'(busy), 1);
        chk("same_cycle_no_fs", int'(false_start), 0);
        react = 1'b0;
        wait_go("b40");
        react_after("b40", 40, 0);

        // React held from DONE through the whole dark phase and the GO edge.
        react = 1'b1;
        step(3);
        chk("held_done_still_valid", int'(rt_valid), 1);
        press_start();
        wait_go("held");
        step(10 * P);
        chk("held_no_result", int'(rt_valid), 0);
        chk("held_still_busy", int'(busy), 1);
        react = 1'b0;
        react_after("b25", 25, 10 * P);

        // Timeout round.
        press_start();
        wait_go("tmo");
        push("tmo", RT_MAX, 1, 0);
        n = 0;
        while (!rt_valid && n < RT_MAX * P + 50) begin
            step(1);
            n++;
        end
        chk("tmo_cycles", n, RT_MAX * P + 1);
        step(2);

        // Start press during GO is ignored; react at 30 ticks.
        press_start();
        wait_go("b30");
        step(10 * P);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("go_ignores_start_busy", int'(busy), 1);
        chk("go_ignores_start_disp", int'(disp), 0);
        react_after("b30", 30, 10 * P + 1);

        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
